// File: rtl/slowclk_pkg.sv
// Shared types and default sizing for the slow-clock monitor.
package slowclk_pkg;

  localparam int          DEF_CNT_W   = 32;
  localparam int unsigned DEF_TIMEOUT = 200000000;

  typedef enum logic [1:0] {
    ST_SEEK = 2'd0,
    ST_ARM  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Three-flop synchronizer for the asynchronous slow clock with edge detects.
module sync_edge (
  input  logic i_clk50,
  input  logic i_rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise_det,
  output logic o_fall_det
);

  // r_sync[0]=s1 (metastability catch), r_sync[1]=s2, r_sync[2]=s3
  logic [2:0] r_sync;

  always_ff @(posedge i_clk50 or posedge i_rst) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[1:0], i_d};
  end

  assign o_level    = r_sync[1];
  assign o_rise_det =  r_sync[1] & ~r_sync[2];
  assign o_fall_det = ~r_sync[1] &  r_sync[2];

endmodule

// File: rtl/slowclk_monitor.sv
// Measures period/high time of an asynchronous slow clock in clk50 cycles,
// emits edge strobes and flags loss of the slow clock.
module slowclk_monitor
  import slowclk_pkg::*;
#(
  parameter int          CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic             i_clk50,
  input  logic             i_rst,
  input  logic             i_slow_in,
  output logic             o_rise,
  output logic             o_fall,
  output logic [CNT_W-1:0] o_period,
  output logic             o_period_valid,
  output logic [CNT_W-1:0] o_high_time,
  output logic             o_stalled,
  output logic             o_locked
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic             w_level;
  logic             w_rise_det;
  logic             w_fall_det;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_stall;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_upd_period;
  logic             w_upd_high;
  logic             w_set_lock;

  sync_edge u_sync (
    .i_clk50    (i_clk50),
    .i_rst      (i_rst),
    .i_d        (i_slow_in),
    .o_level    (w_level),
    .o_rise_det (w_rise_det),
    .o_fall_det (w_fall_det)
  );

  // cnt saturates below TIMEOUT, so +1 never wraps at CNT_W bits
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_stall   = (r_cnt == CNT_MAX) && !w_rise_det;

  always_ff @(posedge i_clk50 or posedge i_rst) begin
    if (i_rst)                r_cnt <= '0;
    else if (w_rise_det)      r_cnt <= '0;
    else if (r_cnt != CNT_MAX) r_cnt <= w_cnt_inc;
  end

  always_ff @(posedge i_clk50 or posedge i_rst) begin
    if (i_rst) r_state <= ST_SEEK;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_upd_period = 1'b0;
    w_upd_high   = 1'b0;
    w_set_lock   = 1'b0;
    case (r_state)
      ST_SEEK: begin
        // first rise only opens the window; the interval before it is partial
        if (w_rise_det) w_state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (w_fall_det && !w_level) w_upd_high = 1'b1;
        if (w_rise_det) begin
          w_upd_period = 1'b1;
          w_set_lock   = 1'b1;
          w_state_nxt  = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (w_fall_det && !w_level) w_upd_high   = 1'b1;
        if (w_rise_det)             w_upd_period = 1'b1;
      end
      default: w_state_nxt = ST_SEEK;
    endcase
    // a fall at the stall point measures nothing meaningful, so it is dropped
    if (w_stall) begin
      w_state_nxt = ST_SEEK;
      w_upd_high  = 1'b0;
    end
  end

  always_ff @(posedge i_clk50 or posedge i_rst) begin
    if (i_rst) begin
      o_rise         <= 1'b0;
      o_fall         <= 1'b0;
      o_period_valid <= 1'b0;
      o_period       <= '0;
      o_high_time    <= '0;
      o_stalled      <= 1'b0;
      o_locked       <= 1'b0;
    end else begin
      o_rise         <= w_rise_det;
      o_fall         <= w_fall_det;
      o_period_valid <= w_upd_period;
      if (w_upd_period) o_period    <= w_cnt_inc;
      if (w_upd_high)   o_high_time <= w_cnt_inc;
      if (w_stall) begin
        o_stalled <= 1'b1;
        o_locked  <= 1'b0;
      end else begin
        if (w_rise_det) o_stalled <= 1'b0;
        if (w_set_lock) o_locked  <= 1'b1;
      end
    end
  end

endmodule
